semamem_client: RTL and testbench
=================================

Name: semamem_client

Overview:
- Bus-initiator companion to the semaphore memory responder.
- Turns single-cycle client commands into correctly formed semaphore bus cycles:
  - acquire: atomic read-decrement by 1, with retry and backoff
  - release: write-increment by 1..15
  - peek: absolute read
  - set: absolute write
- Sits between a CPU/accelerator command port and the semaphore memory.
- Guarantees the strobe drop between accesses that the responder's edge-triggered update requires.

Parameters:
- MAX_TRIES, 16, acquire attempts before failing; 0 = retry forever.
- BACKOFF, 8, idle cycles between failed acquire attempts (1..255).
- BUS_TO, 64, cycles waiting for ack_i before aborting with error (2..1023).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- req_i, input, 1, command request; sampled only when busy_o=0.
- op_i, input, 2, command: 00 acquire, 01 release, 10 peek, 11 set.
- sem_i, input, 8, semaphore number.
- amt_i, input, 4, release increment; ignored for other ops.
- val_i, input, 8, set value.
- busy_o, output, 1, command in progress.
- done_o, output, 1, one-cycle completion pulse.
- ok_o, output, 1, valid with done_o; 1 = success.
- err_o, output, 1, valid with done_o; 1 = bus timeout.
- val_o, output, 8, value returned by the last bus read; held until the next read completes.
- cs_o, cyc_o, stb_o, output, 1 each, bus cycle controls; always asserted and deasserted together.
- we_o, output, 1, bus write enable.
- adr_o, output, 13, bus address.
- dat_o, output, 8, bus write data.
- ack_i, input, 1, bus acknowledge.
- dat_i, input, 8, bus read data.

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, done, ok, err, val_o, cs/cyc/stb, we, adr, dat); try and timeout counters cleared.
- Reset mid-operation: strobes drop on the next edge; the command is lost; no done_o.

Command capture and addressing:
- IDLE with req_i=1: latch op, sem, amt, val; busy_o=1 next cycle; enter BUS.
- adr_o composition:
  - acquire: {0, sem, 4'h1}
  - release: {0, sem, amt}
  - peek: {1, sem, 4'h0}
  - set: {1, sem, 4'h0}
- we_o: 1 for release and set; 0 for acquire and peek.
- dat_o: val for set; 0 otherwise.
- Address, data and we_o are stable for the whole strobe.

BUS state:
- cs/cyc/stb held at 1 until ack_i=1.
- On ack: capture dat_i into val_o for reads; drop strobes on the next edge; enter GAP.
- Timeout counter increments every BUS cycle without ack. When it reaches BUS_TO: drop strobes; done_o=1, err_o=1, ok_o=0; return to IDLE.

GAP state:
- Exactly one cycle with strobes low.
- Mandatory before any further strobe, so the responder sees a fresh rising edge.
- Decides completion:
  - release, set, peek: done_o=1, ok_o=1.
  - acquire, val_o != 0: success; done_o=1, ok_o=1. The responder has decremented the semaphore.
  - acquire, val_o == 0: failure; the responder saturated at 0, so no change occurred.
    - If MAX_TRIES != 0 and the try count equals MAX_TRIES: done_o=1, ok_o=0, err_o=0.
    - Otherwise: increment the try count and enter BACKOFF.

BACKOFF state:
- Strobes low for BACKOFF cycles, then re-enter BUS with an identical address.
- Total strobe-low time between attempts = 1 + BACKOFF cycles.

Completion:
- done_o, ok_o, err_o are valid in the same cycle; ok_o and err_o return to 0 the cycle after done_o.
- busy_o falls in the cycle done_o is high.
- A new req_i may be accepted in the cycle after done_o.
- req_i while busy_o=1 is ignored, not queued.
- Single ack cycle expected; ack_i outside BUS is ignored.

Counter widths:
- Try counter: 8 bits, compared to MAX_TRIES.
- Timeout counter: 10 bits.

Test Plan:
- Acquire, sem=0x05 holding 3: one read, adr_o=0x0051, we_o=0 → val_o=3, done_o with ok_o=1; peek then returns 2 at adr_o=0x1050.
- Acquire, sem=0x07 holding 0, MAX_TRIES=4, BACKOFF=8: exactly 4 strobes, 9 low cycles between strobes → done_o with ok_o=0, err_o=0; semaphore still 0.
- Acquire on an empty semaphore, then another agent writes 1 during backoff: next attempt → ok_o=1; semaphore 0.
- Release, sem=0x03 holding 0xFD, amt=4: write at adr_o=0x0034 → ok_o=1; peek returns 0xFF (saturation).
- Set, sem=0xA0, val=0x5A: write at adr_o=0x1A00 with dat_o=0x5A. Then peek → val_o=0x5A. The two strobes are separated by at least one low cycle.
- Bus timeout and reset:
  - ack_i tied low, BUS_TO=64: strobes drop after 64 cycles → done_o with err_o=1, ok_o=0.
  - rst_i pulsed mid-BUS: all outputs 0 on the next edge; no done_o.

Source files
------------

// File: rtl/semamem_client_if.sv
// Semaphore memory bus: initiator drives the strobe, address and write data;
// the responder returns a single-cycle ack with read data.
interface semamem_client_if;
    logic        cs_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [12:0] adr_o;
    logic [7:0]  dat_o;
    logic        ack_i;
    logic [7:0]  dat_i;

    modport master (
        output cs_o, cyc_o, stb_o, we_o, adr_o, dat_o,
        input  ack_i, dat_i
    );

    modport slave (
        input  cs_o, cyc_o, stb_o, we_o, adr_o, dat_o,
        output ack_i, dat_i
    );
endinterface

// File: rtl/semamem_client.sv
// Command-to-bus initiator for the semaphore memory: acquire with retry/backoff,
// release, peek and set, with a guaranteed strobe-low cycle between accesses.
module semamem_client #(
    parameter int unsigned MAX_TRIES = 16,
    parameter int unsigned BACKOFF   = 8,
    parameter int unsigned BUS_TO    = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic [1:0]              op_i,
    input  logic [7:0]              sem_i,
    input  logic [3:0]              amt_i,
    input  logic [7:0]              val_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ok_o,
    output logic                    err_o,
    output logic [7:0]              val_o,
    semamem_client_if.master        bus
);

    typedef enum logic [1:0] {StIdle, StBus, StGap, StBackoff} state_e;

    localparam logic [1:0] OpAcquire = 2'b00;
    localparam logic [1:0] OpRelease = 2'b01;
    localparam logic [1:0] OpPeek    = 2'b10;
    localparam logic [1:0] OpSet     = 2'b11;

    localparam logic [9:0] BusToLast   = 10'(BUS_TO - 1);
    localparam logic [7:0] BackoffLast = 8'(BACKOFF - 1);
    localparam logic [7:0] MaxTriesW   = 8'(MAX_TRIES);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  try_q, try_d;
    logic [9:0]  to_q, to_d;
    logic [7:0]  bo_q, bo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [7:0]  val_q, val_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [12:0] adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        try_d   = try_q;
        to_d    = to_q;
        bo_d    = bo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        val_d   = val_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    op_d    = op_i;
                    busy_d  = 1'b1;
                    stb_d   = 1'b1;
                    to_d    = '0;
                    try_d   = 8'd1;
                    state_d = StBus;
                    unique case (op_i)
                        OpAcquire: begin
                            adr_d = {1'b0, sem_i, 4'h1};
                            we_d  = 1'b0;
                            dat_d = '0;
                        end
                        OpRelease: begin
                            adr_d = {1'b0, sem_i, amt_i};
                            we_d  = 1'b1;
                            dat_d = '0;
                        end
                        OpPeek: begin
                            adr_d = {1'b1, sem_i, 4'h0};
                            we_d  = 1'b0;
                            dat_d = '0;
                        end
                        OpSet: begin
                            adr_d = {1'b1, sem_i, 4'h0};
                            we_d  = 1'b1;
                            dat_d = val_i;
                        end
                    endcase
                end
            end

            StBus: begin
                if (bus.ack_i) begin
                    if (!we_q) begin
                        val_d = bus.dat_i;
                    end
                    stb_d   = 1'b0;
                    state_d = StGap;
                end else if (to_q == BusToLast) begin
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 10'd1;
                end
            end

            StGap: begin
                // A zero read on acquire means the responder saturated: nothing was taken.
                if (op_q == OpAcquire && val_q == 8'd0) begin
                    if (MAX_TRIES != 0 && try_q == MaxTriesW) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        try_d   = try_q + 8'd1;
                        bo_d    = '0;
                        state_d = StBackoff;
                    end
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    state_d = StIdle;
                end
            end

            StBackoff: begin
                if (bo_q == BackoffLast) begin
                    stb_d   = 1'b1;
                    to_d    = '0;
                    state_d = StBus;
                end else begin
                    bo_d = bo_q + 8'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            try_q   <= '0;
            to_q    <= '0;
            bo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            val_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            try_q   <= try_d;
            to_q    <= to_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            val_q   <= val_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ok_o      = ok_q;
    assign err_o     = err_q;
    assign val_o     = val_q;
    assign bus.cs_o  = stb_q;
    assign bus.cyc_o = stb_q;
    assign bus.stb_o = stb_q;
    assign bus.we_o  = we_q;
    assign bus.adr_o = adr_q;
    assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_semamem_client.sv
// Directed bench for semamem_client: a behavioural semaphore responder, a strobe
// monitor, and a scoreboard of expected completions popped on done_o.
module tb_semamem_client;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [1:0] op  = '0;
    logic [7:0] sem = '0;
    logic [3:0] amt = '0;
    logic [7:0] val = '0;
    logic       busy, done, ok, err;
    logic [7:0] val_out;

    semamem_client_if bus ();

    semamem_client #(
        .MAX_TRIES(4),
        .BACKOFF  (8),
        .BUS_TO   (64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req),
        .op_i  (op),
        .sem_i (sem),
        .amt_i (amt),
        .val_i (val),
        .busy_o(busy),
        .done_o(done),
        .ok_o  (ok),
        .err_o (err),
        .val_o (val_out),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Responder model: read-decrement / write-increment (saturating) or absolute access.
    logic [7:0] mem [256];
    logic       ack_en    = 1'b1;
    logic       agent_we  = 1'b0;
    logic [7:0] agent_sem = '0;
    logic [7:0] agent_val = '0;
    logic       ack_r     = 1'b0;
    logic [7:0] rdat_r    = '0;

    assign bus.ack_i = ack_r;
    assign bus.dat_i = rdat_r;

    always @(posedge clk) begin
        logic [7:0] s;
        logic [8:0] sum;
        s = bus.adr_o[11:4];
        if (agent_we) mem[agent_sem] <= agent_val;
        if (bus.stb_o && !ack_r && ack_en) begin
            ack_r <= 1'b1;
            if (bus.adr_o[12]) begin
                if (bus.we_o) mem[s] <= bus.dat_o;
                else rdat_r <= mem[s];
            end else if (bus.we_o) begin
                sum = {1'b0, mem[s]} + {5'd0, bus.adr_o[3:0]};
                mem[s] <= sum[8] ? 8'hFF : sum[7:0];
            end else begin
                rdat_r <= mem[s];
                mem[s] <= (mem[s] == 8'd0) ? 8'd0 : mem[s] - 8'd1;
            end
        end else begin
            ack_r <= 1'b0;
        end
    end

    // Strobe monitor, cleared at the start of each command.
    logic        mon_clr = 1'b0;
    logic        stb_prev = 1'b0, got_first = 1'b0;
    int          n_str = 0, gap_min = 255, gap_max = 0, low_run = 0, hi_run = 0;
    int          hi_last = 0, last_gap = 0, n_done = 0;
    logic [12:0] first_adr = '0;
    logic        first_we = 1'b0;
    logic [7:0]  first_dat = '0;

    always @(negedge clk) begin
        stb_prev <= bus.stb_o;
        if (done) n_done <= n_done + 1;
        if (bus.stb_o && !stb_prev) begin
            last_gap <= low_run;
            hi_run   <= 1;
            if (mon_clr || !got_first) begin
                first_adr <= bus.adr_o;
                first_we  <= bus.we_o;
                first_dat <= bus.dat_o;
            end
            if (got_first && !mon_clr) begin
                if (low_run < gap_min) gap_min <= low_run;
                if (low_run > gap_max) gap_max <= low_run;
            end
            got_first <= 1'b1;
            n_str     <= mon_clr ? 1 : n_str + 1;
        end else if (bus.stb_o) begin
            hi_run <= hi_run + 1;
        end else begin
            if (stb_prev) begin
                hi_last <= hi_run;
                low_run <= 1;
            end else begin
                low_run <= low_run + 1;
            end
        end
        if (mon_clr && !(bus.stb_o && !stb_prev)) begin
            got_first <= 1'b0;
            n_str     <= 0;
        end
        if (mon_clr) begin
            gap_min <= 255;
            gap_max <= 0;
        end
    end

    typedef struct {
        string       tag;
        logic        ok;
        logic        err;
        logic [7:0]  val;
        logic [12:0] adr;
        logic        we;
        logic [7:0]  dat;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [1:0] o, input logic [7:0] s, input logic [3:0] a,
                             input logic [7:0] v);
        @(posedge clk); #1;
        req = 1'b1; op = o; sem = s; amt = a; val = v; mon_clr = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [1:0] o, input logic [7:0] s,
                         input logic [3:0] a, input logic [7:0] v, input logic e_ok,
                         input logic e_err, input logic [7:0] e_val, input logic [12:0] e_adr,
                         input logic e_we, input logic [7:0] e_dat);
        exp_t e;
        e.tag = tag; e.ok = e_ok; e.err = e_err; e.val = e_val;
        e.adr = e_adr; e.we = e_we; e.dat = e_dat;
        sb.push_back(e);
        drive_req(o, s, a, v);
        @(negedge clk);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_cmd();
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (sb.size() == 0) begin
            check("sb.empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".done"}, {31'd0, seen}, 32'd1);
        check({e.tag, ".busy_low"}, {31'd0, busy}, 32'd0);
        check({e.tag, ".ok"}, {31'd0, ok}, {31'd0, e.ok});
        check({e.tag, ".err"}, {31'd0, err}, {31'd0, e.err});
        check({e.tag, ".val"}, {24'd0, val_out}, {24'd0, e.val});
        @(negedge clk);
        check({e.tag, ".pulse_end"}, {29'd0, done, ok, err}, 32'd0);
        check({e.tag, ".adr"}, {19'd0, first_adr}, {19'd0, e.adr});
        check({e.tag, ".we"}, {31'd0, first_we}, {31'd0, e.we});
        check({e.tag, ".dat"}, {24'd0, first_dat}, {24'd0, e.dat});
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.status", {28'd0, busy, done, ok, err}, 32'd0);
        check("rst.val", {24'd0, val_out}, 32'd0);
        check("rst.strobes", {29'd0, bus.cs_o, bus.cyc_o, bus.stb_o}, 32'd0);
        check("rst.bus", {10'd0, bus.we_o, bus.adr_o, bus.dat_o}, 32'd0);

        // sem 5 = 3, acquire reads 3, peek then sees 2
        issue("set5", 2'b11, 8'h05, 4'h0, 8'h03, 1, 0, 8'h00, 13'h1050, 1, 8'h03);
        finish_cmd();
        issue("acq5", 2'b00, 8'h05, 4'h0, 8'h00, 1, 0, 8'h03, 13'h0051, 0, 8'h00);
        finish_cmd();
        issue("peek5", 2'b10, 8'h05, 4'h0, 8'h00, 1, 0, 8'h02, 13'h1050, 0, 8'h00);
        finish_cmd();

        // empty semaphore: four attempts, 1 + BACKOFF low cycles between them
        issue("acq7", 2'b00, 8'h07, 4'h0, 8'h00, 0, 0, 8'h00, 13'h0071, 0, 8'h00);
        finish_cmd();
        check("acq7.strobes", n_str, 32'd4);
        check("acq7.gap_min", gap_min, 32'd9);
        check("acq7.gap_max", gap_max, 32'd9);
        issue("peek7", 2'b10, 8'h07, 4'h0, 8'h00, 1, 0, 8'h00, 13'h1070, 0, 8'h00);
        finish_cmd();

        // another agent posts 1 while the client is backing off
        issue("acq9", 2'b00, 8'h09, 4'h0, 8'h00, 1, 0, 8'h01, 13'h0091, 0, 8'h00);
        for (int i = 0; i < 20 && bus.stb_o; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("acq9.in_backoff", {31'd0, bus.stb_o}, 32'd0);
        @(posedge clk); #1;
        agent_we = 1'b1; agent_sem = 8'h09; agent_val = 8'h01;
        @(posedge clk); #1;
        agent_we = 1'b0;
        finish_cmd();
        check("acq9.strobes", n_str, 32'd2);
        issue("peek9", 2'b10, 8'h09, 4'h0, 8'h00, 1, 0, 8'h00, 13'h1090, 0, 8'h00);
        finish_cmd();

        // release saturates at 0xFF
        issue("set3", 2'b11, 8'h03, 4'h0, 8'hFD, 1, 0, 8'h00, 13'h1030, 1, 8'hFD);
        finish_cmd();
        issue("rel3", 2'b01, 8'h03, 4'h4, 8'h77, 1, 0, 8'h00, 13'h0034, 1, 8'h00);
        finish_cmd();
        issue("peek3", 2'b10, 8'h03, 4'h0, 8'h00, 1, 0, 8'hFF, 13'h1030, 0, 8'h00);
        finish_cmd();

        issue("setA0", 2'b11, 8'hA0, 4'h0, 8'h5A, 1, 0, 8'hFF, 13'h1A00, 1, 8'h5A);
        finish_cmd();
        issue("peekA0", 2'b10, 8'hA0, 4'h0, 8'h00, 1, 0, 8'h5A, 13'h1A00, 0, 8'h00);
        check("peekA0.gap", {31'd0, last_gap >= 1}, 32'd1);
        finish_cmd();

        // no ack: strobe held BUS_TO cycles, then error completion
        ack_en = 1'b0;
        issue("tmo", 2'b00, 8'h11, 4'h0, 8'h00, 0, 1, 8'h5A, 13'h0111, 0, 8'h00);
        finish_cmd();
        check("tmo.hi_cycles", hi_last, 32'd64);

        // reset in the middle of a bus cycle loses the command silently
        drive_req(2'b00, 8'h05, 4'h0, 8'h00);
        repeat (5) @(negedge clk);
        check("rstmid.strobe_up", {31'd0, bus.stb_o}, 32'd1);
        nd = n_done;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid.status", {28'd0, busy, done, ok, err}, 32'd0);
        check("rstmid.val", {24'd0, val_out}, 32'd0);
        check("rstmid.strobes", {29'd0, bus.cs_o, bus.cyc_o, bus.stb_o}, 32'd0);
        check("rstmid.bus", {10'd0, bus.we_o, bus.adr_o, bus.dat_o}, 32'd0);
        repeat (80) @(negedge clk);
        check("rstmid.no_done", n_done, nd);
        ack_en = 1'b1;

        issue("peek5b", 2'b10, 8'h05, 4'h0, 8'h00, 1, 0, 8'h02, 13'h1050, 0, 8'h00);
        finish_cmd();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
